// File: rtl/dii_reg_responder.sv
// Packet-side register endpoint for the debug ring: parses REG read/write
// requests from the router's local port, runs one bus access, and replies.
package dii_pkg;
  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] data;
  } dii_flit;
endpackage

module dii_reg_responder
  import dii_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] id,
  input  dii_flit     debug_in,
  output logic        debug_in_ready,
  output dii_flit     debug_out,
  input  logic        debug_out_ready,
  output logic        reg_request,
  output logic        reg_write,
  output logic [15:0] reg_addr,
  output logic [15:0] reg_wdata,
  input  logic        reg_ack,
  input  logic        reg_err,
  input  logic [15:0] reg_rdata
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [3:0] {
    IDLE, RX_SRC, RX_HDR, RX_ADDR, RX_WDATA, DROP,
    ACCESS, TX_DEST, TX_SRC, TX_HDR, TX_DATA
  } state_t;

  state_t        state, state_n, bad_next;
  logic          in_en;
  logic [15:0]   src_q, rdata_q;
  logic          err_q;
  logic [CW-1:0] cnt;
  logic          in_fire, out_fire, timeout, hdr_ok;

  assign hdr_ok         = (debug_in.data[15:14] == 2'b00) && (debug_in.data[13:11] == 3'b000);
  assign debug_in_ready = in_en && (state inside {IDLE, RX_SRC, RX_HDR, RX_ADDR, RX_WDATA, DROP});
  assign in_fire        = debug_in.valid && debug_in_ready;
  assign out_fire       = debug_out.valid && debug_out_ready;
  assign timeout        = (TIMEOUT != 0) && (cnt == TO_LAST);
  assign reg_request    = (state == ACCESS);
  // A malformed flit that already closes the packet needs no draining.
  assign bad_next       = debug_in.last ? IDLE : DROP;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:     if (in_fire) state_n = (debug_in.data == id && !debug_in.last) ? RX_SRC : bad_next;
      RX_SRC:   if (in_fire) state_n = !debug_in.last ? RX_HDR : bad_next;
      RX_HDR:   if (in_fire) state_n = (hdr_ok && !debug_in.last) ? RX_ADDR : bad_next;
      RX_ADDR:
        if (in_fire) begin
          if (reg_write) state_n = !debug_in.last ? RX_WDATA : IDLE;
          else           state_n = debug_in.last ? ACCESS : DROP;
        end
      RX_WDATA: if (in_fire) state_n = debug_in.last ? ACCESS : DROP;
      DROP:     if (in_fire && debug_in.last) state_n = IDLE;
      ACCESS:   if (reg_err || reg_ack || timeout) state_n = TX_DEST;
      TX_DEST:  if (out_fire) state_n = TX_SRC;
      TX_SRC:   if (out_fire) state_n = TX_HDR;
      TX_HDR:   if (out_fire) state_n = (reg_write || err_q) ? IDLE : TX_DATA;
      TX_DATA:  if (out_fire) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_comb begin
    debug_out = '0;
    unique case (state)
      TX_DEST: begin debug_out.valid = 1'b1; debug_out.data = src_q; end
      TX_SRC:  begin debug_out.valid = 1'b1; debug_out.data = id; end
      TX_HDR: begin
        debug_out.valid = 1'b1;
        debug_out.last  = reg_write || err_q;
        debug_out.data  = {2'b00, 2'b10, reg_write, err_q, 10'd0};
      end
      TX_DATA: begin debug_out.valid = 1'b1; debug_out.last = 1'b1; debug_out.data = rdata_q; end
      default: debug_out = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_en     <= 1'b0;
      src_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      cnt       <= '0;
      reg_write <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
    end else begin
      in_en <= 1'b1;
      cnt   <= (state == ACCESS) ? cnt + 1'b1 : '0;
      if (in_fire) begin
        unique case (state)
          RX_SRC:   src_q     <= debug_in.data;
          RX_HDR:   reg_write <= debug_in.data[10];
          RX_ADDR:  reg_addr  <= debug_in.data;
          RX_WDATA: reg_wdata <= debug_in.data;
          default:  ;
        endcase
      end
      // Error beats ack; a late ack after timeout is never seen here.
      if (state == ACCESS) begin
        if (reg_err) err_q <= 1'b1;
        else if (reg_ack) begin
          err_q   <= 1'b0;
          rdata_q <= reg_rdata;
        end else if (timeout) err_q <= 1'b1;
      end
    end
  end

endmodule
